// File: rtl/pwm_note_sequencer.sv
// Purpose: walks a song table in a synchronous ROM and drives tone period/enable for each note.
// Latency: per note slot, 1 fetch + 1 decode + dur*BEAT_DIV play + GAP_CYCLES silent cycles.
// Backpressure: none; the ROM has fixed 1-cycle latency. stop aborts at once, start is ignored while busy.
module pwm_note_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int BEAT_DIV   = 6281250,
    parameter int GAP_CYCLES = 502500
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [15:0]       rom_data,
    output logic [11:0]       tone_period,
    output logic              tone_en,
    output logic              note_strobe,
    output logic              busy,
    output logic              done
);

    localparam int BW = $clog2(BEAT_DIV);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_PLAY,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [11:0]       period_q, period_d;
    logic [3:0]        beats_q, beats_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic              rom_rd_q, rom_rd_d;
    logic              tone_en_q, tone_en_d;
    logic              strobe_q, strobe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [3:0]        rom_dur;
    logic [11:0]       rom_period;

    assign rom_dur    = rom_data[15:12];
    assign rom_period = rom_data[11:0];

    // The pointer register doubles as the ROM address; it only matters while rom_rd is high.
    assign rom_addr    = ptr_q;
    assign rom_rd      = rom_rd_q;
    assign tone_period = period_q;
    assign tone_en     = tone_en_q;
    assign note_strobe = strobe_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // State and output registers; outputs are precomputed for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            period_q   <= '0;
            beats_q    <= '0;
            beat_cnt_q <= '0;
            gap_cnt_q  <= '0;
            rom_rd_q   <= 1'b0;
            tone_en_q  <= 1'b0;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            period_q   <= period_d;
            beats_q    <= beats_d;
            beat_cnt_q <= beat_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            rom_rd_q   <= rom_rd_d;
            tone_en_q  <= tone_en_d;
            strobe_q   <= strobe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state sequencing plus the registered output values for the next cycle.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        period_d   = period_q;
        beats_d    = beats_q;
        beat_cnt_d = beat_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        rom_rd_d   = 1'b0;
        tone_en_d  = 1'b0;
        strobe_d   = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    ptr_d    = '0;
                    state_d  = S_FETCH;
                    rom_rd_d = 1'b1;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (rom_dur == 4'd0) begin
                    // Looping from address 0 onto a marker at 0 would spin forever, so finish instead.
                    if (loop_en && (ptr_q != '0)) begin
                        ptr_d    = '0;
                        state_d  = S_FETCH;
                        rom_rd_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    period_d   = rom_period;
                    beats_d    = rom_dur;
                    beat_cnt_d = '0;
                    state_d    = S_PLAY;
                    strobe_d   = 1'b1;
                    tone_en_d  = (rom_period != 12'd0);
                end
            end
            S_PLAY: begin
                tone_en_d = (period_q != 12'd0);
                if (beat_cnt_q == BEAT_LAST) begin
                    beat_cnt_d = '0;
                    beats_d    = beats_q - 4'd1;
                    if (beats_q == 4'd1) begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                        tone_en_d = 1'b0;
                    end
                end else begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    ptr_d    = ptr_q + ADDR_W'(1);
                    state_d  = S_FETCH;
                    rom_rd_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything and silences the tone generator completely.
        if (stop && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            period_d  = '0;
            rom_rd_d  = 1'b0;
            tone_en_d = 1'b0;
            strobe_d  = 1'b0;
            done_d    = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

endmodule
